data_ram: RTL and testbench



---
 rtl/data_ram_pkg.sv | 24 ++
 rtl/data_ram.sv | 50 +++++
 tb/tb_data_ram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/data_ram_pkg.sv
// Shared widths, types and the byte-lane merge helper for the data memory.
package data_ram_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_BYTES  = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [NUM_BYTES-1:0]  be_t;

    // Lanes with a clear enable keep the old byte; enabled lanes take the new one.
    function automatic word_t byte_merge(input word_t old_word, input word_t new_data, input be_t we);
        word_t merged;
        merged = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram.sv
// 256 x 32 data memory: one byte-enabled write/read port and one read-only port.
// Define DATA_RAM_OUTREG_EN to register both read outputs (one-cycle latency).
module data_ram
    import data_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [NUM_BYTES-1:0]  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] spo,
    input  logic [ADDR_WIDTH-1:0] dpra,
    output logic [DATA_WIDTH-1:0] dpo
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    word_t mem [DEPTH];
    word_t next_word;

    assign next_word = byte_merge(mem[a], d, we);

    // Reset clears the whole array and takes priority over any write in that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (|we) begin
            mem[a] <= next_word;
        end
    end

`ifdef DATA_RAM_OUTREG_EN
    // Registered reads see the contents as updated by this same edge's write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spo <= '0;
            dpo <= '0;
        end else begin
            spo <= next_word;
            dpo <= (dpra == a) ? next_word : mem[dpra];
        end
    end
`else
    assign spo = mem[a];
    assign dpo = mem[dpra];
`endif

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram (both read modes, via DATA_RAM_OUTREG_EN).
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [3:0]  we;
    logic [31:0] d;
    logic [31:0] spo;
    logic [7:0]  dpra;
    logic [31:0] dpo;

    int check_count;
    int fail_count;

    data_ram dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .we   (we),
        .d    (d),
        .spo  (spo),
        .dpra (dpra),
        .dpo  (dpo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One write edge, then the enables are dropped again.
    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        a  = addr;
        d  = data;
        we = be;
        @(posedge clk);
        #1;
        we = 4'b0000;
    endtask

    task automatic readCheck(input string tag, input logic [7:0] addr, input logic [7:0] raddr,
                             input logic [31:0] exp_spo, input logic [31:0] exp_dpo);
        a    = addr;
        dpra = raddr;
        we   = 4'b0000;
`ifdef DATA_RAM_OUTREG_EN
        @(posedge clk);
`endif
        #1;
        checkOutput({tag, "_spo"}, spo, exp_spo);
        checkOutput({tag, "_dpo"}, dpo, exp_dpo);
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst_n = 1'b0;
        a     = 8'h00;
        dpra  = 8'h00;
        we    = 4'b0000;
        d     = 32'h0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        readCheck("rst_00", 8'h00, 8'h00, 32'h0, 32'h0);
        readCheck("rst_7f", 8'h7F, 8'h7F, 32'h0, 32'h0);
        readCheck("rst_ff", 8'hFF, 8'hFF, 32'h0, 32'h0);

        $display("[TB] full-word writes");
        applyStimulus(8'h00, 32'hDEADBEEF, 4'b1111);
        readCheck("word0", 8'h00, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF);
        applyStimulus(8'h01, 32'h12345678, 4'b1111);
        readCheck("word1", 8'h01, 8'h01, 32'h12345678, 32'h12345678);

        readCheck("dual", 8'h00, 8'h01, 32'hDEADBEEF, 32'h12345678);

        $display("[TB] byte writes");
        applyStimulus(8'h02, 32'hFFFFFFFF, 4'b1111);
        applyStimulus(8'h02, 32'h000000AA, 4'b0001);
        readCheck("byte0", 8'h02, 8'h02, 32'hFFFFFFAA, 32'hFFFFFFAA);
        applyStimulus(8'h02, 32'h55000000, 4'b1000);
        readCheck("byte3", 8'h02, 8'h02, 32'h55FFFFAA, 32'h55FFFFAA);
        applyStimulus(8'h02, 32'h00123400, 4'b0110);
        readCheck("byte12", 8'h02, 8'h00, 32'h551234AA, 32'hDEADBEEF);

        $display("[TB] collision and idle cycles");
        dpra = 8'h03;
        applyStimulus(8'h03, 32'hCAFEF00D, 4'b1111);
        readCheck("coll", 8'h03, 8'h03, 32'hCAFEF00D, 32'hCAFEF00D);
        d  = 32'h0;
        we = 4'b0000;
        repeat (3) @(posedge clk);
        readCheck("idle", 8'h03, 8'h03, 32'hCAFEF00D, 32'hCAFEF00D);

        $display("[TB] reset during write");
        a     = 8'h04;
        d     = 32'h11111111;
        we    = 4'b1111;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        we    = 4'b0000;
        readCheck("mrst_04", 8'h04, 8'h00, 32'h0, 32'h0);
        readCheck("mrst_12", 8'h01, 8'h02, 32'h0, 32'h0);
        readCheck("mrst_33", 8'h03, 8'h03, 32'h0, 32'h0);

`ifndef DATA_RAM_OUTREG_EN
        $display("[TB] read around write edge");
        a    = 8'h05;
        dpra = 8'h05;
        d    = 32'hA5A5A5A5;
        we   = 4'b1111;
        #1;
        checkOutput("pre_wr_spo", spo, 32'h0);
        checkOutput("pre_wr_dpo", dpo, 32'h0);
        @(posedge clk);
        #1;
        we = 4'b0000;
        checkOutput("post_wr_spo", spo, 32'hA5A5A5A5);
        checkOutput("post_wr_dpo", dpo, 32'hA5A5A5A5);
`else
        $display("[TB] registered read latency");
        a    = 8'h05;
        dpra = 8'h05;
        d    = 32'hA5A5A5A5;
        we   = 4'b1111;
        #1;
        checkOutput("pre_wr_spo", spo, 32'h0);
        @(posedge clk);
        #1;
        we = 4'b0000;
        checkOutput("post_wr_spo", spo, 32'hA5A5A5A5);
        checkOutput("post_wr_dpo", dpo, 32'hA5A5A5A5);
`endif

        readCheck("top", 8'hFF, 8'h05, 32'h0, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
